// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: opcode encodings, instruction field layout,
// fetch FSM state encodings and fixed vector addresses.
package fetch_unit_pkg;

  localparam int unsigned OPC_W = 5;

  typedef logic [OPC_W-1:0] opcode_t;
  typedef logic [2:0]       fetch_state_t;

  localparam opcode_t OP_LDM = 5'h0C;
  localparam opcode_t OP_LDD = 5'h0D;
  localparam opcode_t OP_STD = 5'h0E;
  localparam opcode_t OP_INT = 5'h1F;

  localparam fetch_state_t S_VEC_HI = 3'd0;
  localparam fetch_state_t S_VEC_LO = 3'd1;
  localparam fetch_state_t S_FETCH  = 3'd2;
  localparam fetch_state_t S_IMM    = 3'd3;
  localparam fetch_state_t S_INT_HI = 3'd4;
  localparam fetch_state_t S_INT_LO = 3'd5;

  localparam int unsigned RST_VEC_HI_ADDR = 0;
  localparam int unsigned RST_VEC_LO_ADDR = 1;
  localparam int unsigned INT_VEC_HI_ADDR = 2;
  localparam int unsigned INT_VEC_LO_ADDR = 3;

  // Opcodes that carry a second (immediate) word.
  function automatic logic is_two_word(input opcode_t opc);
    return (opc == OP_LDM) || (opc == OP_LDD) || (opc == OP_STD);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: stall holds every field, flush drops the valid bit.
module if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned INSTR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_stall,
  input  logic                   i_flush,
  input  logic                   i_valid,
  input  logic [INSTR_WIDTH-1:0] i_instr,
  input  logic [INSTR_WIDTH-1:0] i_imm,
  input  logic [PC_WIDTH-1:0]    i_pc,
  output logic                   o_valid,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [INSTR_WIDTH-1:0] o_imm,
  output logic [PC_WIDTH-1:0]    o_pc
);

  logic                   r_valid;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic [INSTR_WIDTH-1:0] r_imm;
  logic [PC_WIDTH-1:0]    r_pc;
  logic                   w_load;

  assign w_load = i_valid && !i_flush;

  // Payload only moves with a real emission; bubbles keep the last payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_imm   <= '0;
      r_pc    <= '0;
    end else if (!i_stall) begin
      r_valid <= w_load;
      if (w_load) begin
        r_instr <= i_instr;
        r_imm   <= i_imm;
        r_pc    <= i_pc;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_imm   = r_imm;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: reset/interrupt vector load, one- and two-word instruction
// assembly, branch redirect, stall and flush handling.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned PC_WIDTH     = 32,
  parameter int unsigned INSTR_WIDTH  = 16,
  parameter int unsigned OPCODE_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [PC_WIDTH-1:0]     imem_addr,
  input  logic [INSTR_WIDTH-1:0]  imem_rdata,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    branch_taken,
  input  logic [PC_WIDTH-1:0]     branch_target,
  input  logic                    int_req,
  output logic                    if_valid,
  output logic [INSTR_WIDTH-1:0]  if_instr,
  output logic [INSTR_WIDTH-1:0]  if_imm,
  output logic [PC_WIDTH-1:0]     if_pc,
  output logic [OPCODE_WIDTH-1:0] opcode,
  output logic                    int_ack
);

  fetch_state_t           r_state;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [INSTR_WIDTH-1:0] r_buf;
  logic [INSTR_WIDTH-1:0] r_vec_hi;
  logic                   r_pending;
  logic                   r_int_ack;

  fetch_state_t           w_state_nxt;
  logic [PC_WIDTH-1:0]    w_pc_nxt;
  logic [INSTR_WIDTH-1:0] w_buf_nxt;
  logic [INSTR_WIDTH-1:0] w_vec_hi_nxt;
  logic                   w_pending_nxt;
  logic                   w_int_ack_nxt;

  logic                    w_branch;
  logic                    w_hold;
  logic [OPCODE_WIDTH-1:0] w_fetch_opc;
  logic                    w_two_word;
  logic [PC_WIDTH-1:0]     w_pc_inc;
  logic [PC_WIDTH-1:0]     w_vec_pc;
  logic [INSTR_WIDTH-1:0]  w_int_instr;

  logic                   w_ld_valid;
  logic [INSTR_WIDTH-1:0] w_ld_instr;
  logic [INSTR_WIDTH-1:0] w_ld_imm;
  logic [PC_WIDTH-1:0]    w_ld_pc;

  // Redirects are only honoured while fetching program text, never mid-vector.
  assign w_branch    = branch_taken && ((r_state == S_FETCH) || (r_state == S_IMM));
  assign w_hold      = stall && !w_branch;
  assign w_fetch_opc = imem_rdata[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  assign w_two_word  = is_two_word(OPC_W'(w_fetch_opc));
  assign w_pc_inc    = r_pc + PC_WIDTH'(1);
  assign w_vec_pc    = PC_WIDTH'({r_vec_hi, imem_rdata});
  assign w_int_instr = {OPCODE_WIDTH'(OP_INT), {(INSTR_WIDTH - OPCODE_WIDTH){1'b0}}};

  assign w_pending_nxt = (r_pending && !((r_state == S_INT_LO) && !stall)) || int_req;

  always_comb begin
    case (r_state)
      S_VEC_HI: imem_addr = PC_WIDTH'(RST_VEC_HI_ADDR);
      S_VEC_LO: imem_addr = PC_WIDTH'(RST_VEC_LO_ADDR);
      S_INT_HI: imem_addr = PC_WIDTH'(INT_VEC_HI_ADDR);
      S_INT_LO: imem_addr = PC_WIDTH'(INT_VEC_LO_ADDR);
      default:  imem_addr = r_pc;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_buf_nxt     = r_buf;
    w_vec_hi_nxt  = r_vec_hi;
    w_int_ack_nxt = r_int_ack;
    w_ld_valid    = 1'b0;
    w_ld_instr    = imem_rdata;
    w_ld_imm      = '0;
    w_ld_pc       = w_pc_inc;
    if (w_branch) begin
      w_state_nxt   = S_FETCH;
      w_pc_nxt      = branch_target;
      w_buf_nxt     = '0;
      w_int_ack_nxt = 1'b0;
    end else if (!stall) begin
      w_int_ack_nxt = 1'b0;
      case (r_state)
        S_VEC_HI: begin
          w_vec_hi_nxt = imem_rdata;
          w_state_nxt  = S_VEC_LO;
        end
        S_VEC_LO: begin
          w_pc_nxt    = w_vec_pc;
          w_state_nxt = S_FETCH;
        end
        S_FETCH: begin
          if (r_pending) begin
            // Return address is the un-fetched pc, so the word here is replayed.
            w_ld_valid  = 1'b1;
            w_ld_instr  = w_int_instr;
            w_ld_pc     = r_pc;
            w_state_nxt = S_INT_HI;
          end else if (w_two_word) begin
            w_buf_nxt   = imem_rdata;
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = S_IMM;
          end else begin
            w_ld_valid = 1'b1;
            w_pc_nxt   = w_pc_inc;
          end
        end
        S_IMM: begin
          w_ld_valid  = 1'b1;
          w_ld_instr  = r_buf;
          w_ld_imm    = imem_rdata;
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = S_FETCH;
        end
        S_INT_HI: begin
          w_vec_hi_nxt = imem_rdata;
          w_state_nxt  = S_INT_LO;
        end
        S_INT_LO: begin
          w_pc_nxt      = w_vec_pc;
          w_int_ack_nxt = 1'b1;
          w_state_nxt   = S_FETCH;
        end
        default: w_state_nxt = S_VEC_HI;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_VEC_HI;
      r_pc      <= '0;
      r_buf     <= '0;
      r_vec_hi  <= '0;
      r_pending <= 1'b0;
      r_int_ack <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_buf     <= w_buf_nxt;
      r_vec_hi  <= w_vec_hi_nxt;
      r_pending <= w_pending_nxt;
      r_int_ack <= w_int_ack_nxt;
    end
  end

  if_id_reg #(
    .PC_WIDTH   (PC_WIDTH),
    .INSTR_WIDTH(INSTR_WIDTH)
  ) u_if_id_reg (
    .clk    (clk),
    .rst    (rst),
    .i_stall(w_hold),
    .i_flush(flush || w_branch),
    .i_valid(w_ld_valid),
    .i_instr(w_ld_instr),
    .i_imm  (w_ld_imm),
    .i_pc   (w_ld_pc),
    .o_valid(if_valid),
    .o_instr(if_instr),
    .o_imm  (if_imm),
    .o_pc   (if_pc)
  );

  assign opcode  = if_instr[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  assign int_ack = r_int_ack;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a scoreboard of expected emissions.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int unsigned PW = 32;
  localparam int unsigned IW = 16;
  localparam int unsigned OW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic          branch_taken = 1'b0;
  logic [PW-1:0] branch_target = '0;
  logic          int_req = 1'b0;
  logic          if_valid;
  logic [IW-1:0] if_instr;
  logic [IW-1:0] if_imm;
  logic [PW-1:0] if_pc;
  logic [OW-1:0] opcode;
  logic          int_ack;

  logic [IW-1:0] mem [256];
  assign imem_rdata = mem[imem_addr[7:0]];

  always #5 clk = ~clk;

  fetch_unit #(
    .PC_WIDTH    (PW),
    .INSTR_WIDTH (IW),
    .OPCODE_WIDTH(OW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .flush        (flush),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .int_req      (int_req),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_imm       (if_imm),
    .if_pc        (if_pc),
    .opcode       (opcode),
    .int_ack      (int_ack)
  );

  typedef struct {
    logic [IW-1:0] instr;
    logic [IW-1:0] imm;
    logic [PW-1:0] pc;
  } emit_t;

  emit_t sb[$];
  int    n_assert = 0;
  int    n_fail   = 0;
  logic  e_stall;
  logic  e_rst;
  logic [IW-1:0] w_ldm;
  logic [IW-1:0] w_ldd;
  logic [IW-1:0] w_int;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [IW-1:0] instr, input logic [IW-1:0] imm,
                      input logic [PW-1:0] pc);
    emit_t e;
    e.instr = instr;
    e.imm   = imm;
    e.pc    = pc;
    sb.push_back(e);
  endtask

  // One clock; any new emission is popped and compared against the scoreboard.
  task automatic cycle();
    emit_t e;
    @(posedge clk);
    e_stall = stall;
    e_rst   = rst;
    #1;
    if (!e_rst && !e_stall && (if_valid === 1'b1)) begin
      chk("emit_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("emit_instr", 64'(if_instr), 64'(e.instr));
        chk("emit_imm", 64'(if_imm), 64'(e.imm));
        chk("emit_pc", 64'(if_pc), 64'(e.pc));
        chk("emit_opcode", 64'(opcode), 64'(e.instr[IW-1 -: OW]));
      end
    end
  endtask

  task automatic chk_bubble(input string tag, input logic [PW-1:0] addr);
    chk({tag, "_valid"}, 64'(if_valid), 64'd0);
    chk({tag, "_addr"}, 64'(imem_addr), 64'(addr));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {5'h01, 11'(i)};
    w_ldm = {OP_LDM, 11'h001};
    w_ldd = {OP_LDD, 11'h002};
    w_int = {OP_INT, 11'h000};
    mem[8'h00] = 16'h0000;
    mem[8'h01] = 16'h0020;
    mem[8'h02] = 16'h0000;
    mem[8'h03] = 16'h0080;
    mem[8'h20] = w_ldm;
    mem[8'h21] = 16'h1234;
    mem[8'h25] = w_ldd;
    mem[8'h26] = 16'hBEEF;

    // Reset and reset-vector load
    cycle();
    cycle();
    chk("rst_valid", 64'(if_valid), 64'd0);
    chk("rst_instr", 64'(if_instr), 64'd0);
    chk("rst_imm", 64'(if_imm), 64'd0);
    chk("rst_pc", 64'(if_pc), 64'd0);
    chk("rst_ack", 64'(int_ack), 64'd0);
    chk("rst_opcode", 64'(opcode), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    rst = 1'b0;
    cycle();
    chk_bubble("vec_lo", 32'h1);
    cycle();
    chk_bubble("first_fetch", 32'h20);

    // Two-word LDM
    push(w_ldm, 16'h1234, 32'h22);
    cycle();
    chk_bubble("ldm_first", 32'h21);
    cycle();
    chk("ldm_emitted", 64'(sb.size()), 64'd0);
    push(16'h0822, 16'h0, 32'h23);
    cycle();

    // Flush drops one emission but fetch keeps advancing
    flush = 1'b1;
    cycle();
    chk_bubble("flush", 32'h24);
    flush = 1'b0;
    push(16'h0824, 16'h0, 32'h25);
    cycle();

    // Branch while in S_IMM drops the buffered word
    cycle();
    chk_bubble("ldd_first", 32'h26);
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    cycle();
    chk_bubble("br_imm", 32'h40);
    branch_taken = 1'b0;
    push(16'h0840, 16'h0, 32'h41);
    cycle();

    // Stall with interrupt pulse, then service
    stall   = 1'b1;
    int_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      int_req = 1'b0;
      chk("stall_valid", 64'(if_valid), 64'd1);
      chk("stall_instr", 64'(if_instr), 64'h0840);
      chk("stall_pc", 64'(if_pc), 64'h41);
      chk("stall_addr", 64'(imem_addr), 64'h41);
    end
    stall = 1'b0;
    push(w_int, 16'h0, 32'h41);
    cycle();
    chk("int_hi_addr", 64'(imem_addr), 64'h2);
    cycle();
    chk_bubble("int_lo", 32'h3);
    chk("int_lo_ack", 64'(int_ack), 64'd0);
    cycle();
    chk_bubble("int_vec", 32'h80);
    chk("int_ack_pulse", 64'(int_ack), 64'd1);
    push(16'h0880, 16'h0, 32'h81);
    cycle();
    chk("int_ack_drop", 64'(int_ack), 64'd0);
    chk("post_int_addr", 64'(imem_addr), 64'h81);

    // PC wrap
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFF;
    cycle();
    chk_bubble("br_top", 32'hFFFF_FFFF);
    branch_taken = 1'b0;
    push(16'h08FF, 16'h0, 32'h0);
    cycle();
    chk("wrap_addr", 64'(imem_addr), 64'h0);
    push(16'h0000, 16'h0, 32'h1);
    cycle();

    // Reset in S_IMM
    branch_taken  = 1'b1;
    branch_target = 32'h20;
    cycle();
    branch_taken = 1'b0;
    cycle();
    chk_bubble("imm_before_rst", 32'h21);
    rst = 1'b1;
    cycle();
    chk_bubble("rst_imm", 32'h0);
    chk("rst_imm_instr", 64'(if_instr), 64'd0);
    chk("rst_imm_imm", 64'(if_imm), 64'd0);
    chk("rst_imm_pc", 64'(if_pc), 64'd0);
    rst = 1'b0;
    cycle();
    chk_bubble("rst2_vec_lo", 32'h1);
    cycle();
    chk_bubble("rst2_fetch", 32'h20);
    push(w_ldm, 16'h1234, 32'h22);
    cycle();
    chk_bubble("rst2_ldm", 32'h21);
    cycle();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
